// File: rtl/diff_op_pkg.sv
// Shared constants and the saturate/wrap helper for the difference operator.
package diff_op_pkg;

  localparam int ORDER_MIN = 1;
  localparam int ORDER_MAX = 2;

  // Widest intermediate the helper accepts; channel widths must stay well below this.
  localparam int SAT_MAX_W = 64;

  typedef logic signed [SAT_MAX_W-1:0] wide_t;

  // Clamp (or pass through for wrap) a wide signed value to a w-bit signed range.
  // The caller keeps the low w bits, which is the wrapped value when saturate=0.
  // ovf reports whether d was outside the w-bit range, independent of saturate.
  function automatic wide_t sat_w(input wide_t d, input int w, input logic saturate,
                                  output logic ovf);
    wide_t hi;
    wide_t lo;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = -(wide_t'(1) <<< (w - 1));
    ovf = (d > hi) || (d < lo);
    if (saturate && (d > hi))      sat_w = hi;
    else if (saturate && (d < lo)) sat_w = lo;
    else                           sat_w = d;
  endfunction

endpackage

// File: rtl/diff_operator_multi_n_diff_channel.sv
// One channel: sample history, backward-difference adder and saturation/wrap.
module diff_channel
  import diff_op_pkg::*;
#(
  parameter int W        = 16,
  parameter int ORDER    = 1,
  parameter int SATURATE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         take,
  input  logic         clear,
  input  logic         primed,
  input  logic [W-1:0] in_s,
  output logic [W-1:0] out,
  output logic         ovf
);

  logic signed [W-1:0]   prev1_q, prev1_d;
  logic signed [W-1:0]   prev2_q, prev2_d;
  logic signed [W-1:0]   out_q, out_d;
  logic                  ovf_q, ovf_d;

  logic signed [W+1:0]   d;
  wide_t                 d_wide;
  wide_t                 sat_res;
  logic                  d_ovf;
  logic                  sat_unused_hi;

  // Backward difference at W+2 bits so the second-order sum can never overflow.
  always_comb begin
    d = '0;
    if (ORDER == 2) begin
      d = $signed({{2{in_s[W-1]}}, in_s})
        - ($signed({{2{prev1_q[W-1]}}, prev1_q}) <<< 1)
        + $signed({{2{prev2_q[W-1]}}, prev2_q});
    end else begin
      d = $signed({{2{in_s[W-1]}}, in_s}) - $signed({{2{prev1_q[W-1]}}, prev1_q});
    end
    d_wide = {{(SAT_MAX_W-W-2){d[W+1]}}, d};
  end

  // Reduce the wide difference to W bits and flag range overflow.
  always_comb begin
    d_ovf   = 1'b0;
    sat_res = sat_w(d_wide, W, SATURATE != 0, d_ovf);
  end

  assign sat_unused_hi = ^sat_res[SAT_MAX_W-1:W];

  // Next-state for history, output and sticky flag; clear wins over a strobe.
  always_comb begin
    prev1_d = prev1_q;
    prev2_d = prev2_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    if (clear) begin
      prev1_d = '0;
      prev2_d = '0;
      out_d   = '0;
      ovf_d   = 1'b0;
    end else if (take) begin
      prev2_d = prev1_q;
      prev1_d = $signed(in_s);
      if (primed) begin
        out_d = $signed(sat_res[W-1:0]);
        ovf_d = ovf_q | d_ovf;
      end else begin
        out_d = '0;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev1_q <= '0;
      prev2_q <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      prev1_q <= prev1_d;
      prev2_q <= prev2_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out = out_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/diff_operator_multi_n.sv
// N-channel first/second-order backward-difference engine with shared priming control.
module diff_operator_multi_n
  import diff_op_pkg::*;
#(
  parameter int N_CH     = 5,
  parameter int W        = 16,
  parameter int ORDER    = 1,
  parameter int SATURATE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clear,
  input  logic [N_CH-1:0][W-1:0]    in,
  output logic [N_CH-1:0][W-1:0]    out,
  output logic                      out_valid,
  output logic [N_CH-1:0]           ovf,
  output logic [1:0]                prime_cnt
);

  if ((ORDER < ORDER_MIN) || (ORDER > ORDER_MAX)) begin : g_bad_order
    $error("diff_operator_multi_n: ORDER must be 1 or 2");
  end

  localparam logic [1:0] ORDER_CNT = 2'(ORDER);

  logic [1:0] prime_cnt_q, prime_cnt_d;
  logic       out_valid_q, out_valid_d;
  logic       primed;
  logic       take;

  assign primed = (prime_cnt_q == ORDER_CNT);
  assign take   = en & ~clear;

  // Priming counter and valid level; clear discards any simultaneous strobe.
  always_comb begin
    prime_cnt_d = prime_cnt_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      prime_cnt_d = '0;
      out_valid_d = 1'b0;
    end else if (en) begin
      if (primed) begin
        out_valid_d = 1'b1;
      end else begin
        prime_cnt_d = prime_cnt_q + 2'd1;
        out_valid_d = 1'b0;
      end
    end
  end

  // Shared control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prime_cnt_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      prime_cnt_q <= prime_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    diff_channel #(
      .W        (W),
      .ORDER    (ORDER),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .take   (take),
      .clear  (clear),
      .primed (primed),
      .in_s   (in[c]),
      .out    (out[c]),
      .ovf    (ovf[c])
    );
  end

  assign out_valid = out_valid_q;
  assign prime_cnt = prime_cnt_q;

endmodule

// File: tb/tb_diff_operator_multi_n.sv
// Directed bench for diff_operator_multi_n: three instances cover
// ORDER=1 saturating, ORDER=2 saturating and ORDER=1 wrapping.
module tb_diff_operator_multi_n;

  localparam int N_CH = 5;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic en1 = 1'b0, en2 = 1'b0, en3 = 1'b0;
  logic [N_CH-1:0][W-1:0] in_v = '0;

  logic [N_CH-1:0][W-1:0] out1, out2, out3;
  logic                   vld1, vld2, vld3;
  logic [N_CH-1:0]        ovf1, ovf2, ovf3;
  logic [1:0]             pc1, pc2, pc3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  diff_operator_multi_n #(.N_CH(N_CH), .W(W), .ORDER(1), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .clear(clear), .in(in_v),
    .out(out1), .out_valid(vld1), .ovf(ovf1), .prime_cnt(pc1));

  diff_operator_multi_n #(.N_CH(N_CH), .W(W), .ORDER(2), .SATURATE(1)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .clear(clear), .in(in_v),
    .out(out2), .out_valid(vld2), .ovf(ovf2), .prime_cnt(pc2));

  diff_operator_multi_n #(.N_CH(N_CH), .W(W), .ORDER(1), .SATURATE(0)) dut3 (
    .clk(clk), .reset(reset), .en(en3), .clear(clear), .in(in_v),
    .out(out3), .out_valid(vld3), .ovf(ovf3), .prime_cnt(pc3));

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d, input int e);
    in_v[0] = W'(a);
    in_v[1] = W'(b);
    in_v[2] = W'(c);
    in_v[3] = W'(d);
    in_v[4] = W'(e);
  endtask

  // One-cycle strobe on the selected instance; returns on the following negedge.
  task automatic strobe(input int which);
    @(negedge clk);
    case (which)
      1:       en1 = 1'b1;
      2:       en2 = 1'b1;
      default: en3 = 1'b1;
    endcase
    @(negedge clk);
    en1 = 1'b0;
    en2 = 1'b0;
    en3 = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out",   longint'(out1), 0);
    check("rst_vld",   longint'(vld1), 0);
    check("rst_ovf",   longint'(ovf1), 0);
    check("rst_pc",    longint'(pc1), 0);
    reset = 1'b1;

    // ORDER=1 basic difference, strobes 10 cycles apart
    set_in(1, 4, 7, -5, -3);
    strobe(1);
    check("o1_s1_vld", longint'(vld1), 0);
    check("o1_s1_out0", longint'($signed(out1[0])), 0);
    check("o1_s1_pc", longint'(pc1), 1);
    repeat (8) @(negedge clk);
    set_in(0, 2, 4, 6, 5);
    strobe(1);
    check("o1_s2_vld", longint'(vld1), 1);
    check("o1_s2_out0", longint'($signed(out1[0])), -1);
    check("o1_s2_out1", longint'($signed(out1[1])), -2);
    check("o1_s2_out2", longint'($signed(out1[2])), -3);
    check("o1_s2_out3", longint'($signed(out1[3])), 11);
    check("o1_s2_out4", longint'($signed(out1[4])), 8);
    check("o1_s2_ovf", longint'(ovf1), 0);
    repeat (8) @(negedge clk);
    check("o1_hold_vld", longint'(vld1), 1);
    check("o1_hold_out3", longint'($signed(out1[3])), 11);

    // Saturation on ORDER=1
    set_in(32767, 0, 0, 0, 0);
    strobe(1);
    check("sat_a_out0", longint'($signed(out1[0])), 32767);
    check("sat_a_ovf", longint'(ovf1), 0);
    set_in(-32768, 0, 0, 0, 0);
    strobe(1);
    check("sat_b_out0", longint'($signed(out1[0])), -32768);
    check("sat_b_ovf", longint'(ovf1), 5'b00001);
    strobe(1);
    check("sat_c_out0", longint'($signed(out1[0])), 0);
    check("sat_c_ovf0", longint'(ovf1[0]), 1);

    // Wrap mode
    set_in(32767, 0, 0, 0, 0);
    strobe(3);
    check("wrap_a_vld", longint'(vld3), 0);
    set_in(-32768, 0, 0, 0, 0);
    strobe(3);
    check("wrap_b_out0", longint'($signed(out3[0])), 1);
    check("wrap_b_ovf0", longint'(ovf3[0]), 1);
    check("wrap_b_vld", longint'(vld3), 1);

    // ORDER=2
    set_in(1, 0, 0, 0, 0);
    strobe(2);
    check("o2_s1_vld", longint'(vld2), 0);
    check("o2_s1_pc", longint'(pc2), 1);
    set_in(4, 0, 0, 0, 0);
    strobe(2);
    check("o2_s2_vld", longint'(vld2), 0);
    check("o2_s2_pc", longint'(pc2), 2);
    set_in(10, 0, 0, 0, 0);
    strobe(2);
    check("o2_s3_vld", longint'(vld2), 1);
    check("o2_s3_out0", longint'($signed(out2[0])), 3);
    set_in(19, 0, 0, 0, 0);
    strobe(2);
    check("o2_s4_out0", longint'($signed(out2[0])), 3);
    check("o2_s4_ovf", longint'(ovf2), 0);

    // Clear takes priority over a simultaneous strobe
    set_in(100, 0, 0, 0, 0);
    @(negedge clk);
    clear = 1'b1;
    en1   = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    en1   = 1'b0;
    check("clr_vld", longint'(vld1), 0);
    check("clr_ovf", longint'(ovf1), 0);
    check("clr_pc", longint'(pc1), 0);
    check("clr_out0", longint'($signed(out1[0])), 0);
    set_in(5, 0, 0, 0, 0);
    strobe(1);
    check("clr_s1_vld", longint'(vld1), 0);
    set_in(8, 0, 0, 0, 0);
    strobe(1);
    check("clr_s2_vld", longint'(vld1), 1);
    check("clr_s2_out0", longint'($signed(out1[0])), 3);

    // Asynchronous reset between edges
    set_in(-32768, 0, 0, 0, 0);
    strobe(1);
    check("pre_rst_ovf0", longint'(ovf1[0]), 1);
    check("pre_rst_out0", longint'($signed(out1[0])), -32768);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out", longint'(out1), 0);
    check("arst_vld", longint'(vld1), 0);
    check("arst_ovf", longint'(ovf1), 0);
    check("arst_pc", longint'(pc1), 0);
    @(negedge clk);
    reset = 1'b1;
    set_in(5, 0, 0, 0, 0);
    strobe(1);
    check("rep_s1_vld", longint'(vld1), 0);
    check("rep_s1_out0", longint'($signed(out1[0])), 0);
    set_in(7, 0, 0, 0, 0);
    strobe(1);
    check("rep_s2_vld", longint'(vld1), 1);
    check("rep_s2_out0", longint'($signed(out1[0])), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/diff_operator_multi_n.md
Name: diff_operator_multi_n

Overview:
Parametrised successor to the fixed five-channel difference operator. It is an N-channel signed first- or second-order backward-difference engine, strobed by en. Outputs can saturate or wrap, and each channel has a sticky overflow flag. A valid output asserts only once the history is primed. It sits in the feature-extraction path between the sample capture registers and the downstream classifier/recovery logic.

Parameters:
N_CH, 5, number of independent channels
W, 16, signed sample and output width in bits
ORDER, 1, difference order; legal values 1 or 2 (elaboration error otherwise)
SATURATE, 1, 1 = clamp result to W-bit signed range; 0 = two's-complement wrap to W bits

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-low reset
en  input  1  sample strobe; one sample set is consumed per cycle with en=1
clear  input  1  synchronous history flush; active-high
in  input  N_CH x W  signed samples, channel c at in[c]
out  output  N_CH x W  signed difference per channel
out_valid  output  1  out holds a valid difference from the latest en
ovf  output  N_CH  sticky per-channel overflow/saturation flag
prime_cnt  output  2  number of samples held in history (0..ORDER), debug

Behaviour:
- Reset (reset=0, asynchronous):
  - out, prev1, prev2, ovf and prime_cnt go to 0; out_valid goes to 0.
  - Release is synchronous to the clk edge in the usual way.
- Cycle with en=1 and clear=0, latency 1 (registered at the same edge):
  - ORDER=1: d = in - prev1, computed at W+1 bits.
  - ORDER=2: d = in - 2*prev1 + prev2, computed at W+2 bits.
  - prev2 <= prev1; prev1 <= in.
  - If prime_cnt < ORDER:
    - prime_cnt increments.
    - out <= 0, out_valid <= 0.
    - ovf is unchanged.
  - If prime_cnt == ORDER:
    - out <= sat_or_wrap(d), out_valid <= 1.
    - ovf[c] is set if d[c] lies outside [-2^(W-1), 2^(W-1)-1]. This applies in both SATURATE modes.
- Cycle with en=0:
  - All registers hold; out and out_valid persist (a level, not a pulse).
- clear=1: prev1, prev2, prime_cnt, out, out_valid and ovf go to 0 on the next edge.
  - clear has priority over a simultaneous en; that sample is discarded.
- Saturation: results above range clamp to 2^(W-1)-1 and results below clamp to -2^(W-1). Wrap mode keeps the low W bits.
- Channels are fully independent with no cross-channel arithmetic. All channels share en, clear and prime_cnt.
- Reset mid-stream forces a full re-prime: the first ORDER strobes after release produce out_valid=0.
- ovf clears only on reset or clear, never on en.

Decomposition:
- Package diff_op_pkg holds:
  - the ORDER legality constants;
  - the function sat_w (wide signed to W bits, with an overflow bit out), parametrised by W via a parameterised class or generic width argument.
- One sub-module, diff_channel (W, ORDER, SATURATE), holds prev1/prev2, the adder tree and the saturation logic for one channel. It is instantiated N_CH times in a generate loop.
- Top level holds prime_cnt, out_valid and the clear/en priority logic.

Test Plan:
1. ORDER=1, W=16, N_CH=5.
   - Stimulus: en strobe every 10 cycles; in={1,4,7,-5,-3}, then {0,2,4,6,5}.
   - Required response: first strobe gives out_valid=0 and out=0. Second strobe gives out={-1,-2,-3,11,8}, out_valid=1, ovf=0.
2. ORDER=2.
   - Stimulus: ch0 samples 1, 4, 10, 19.
   - Required response: out_valid stays 0 for the first two strobes. Then out[0]=3, then out[0]=3; out_valid=1 from the third strobe.
3. SATURATE=1, W=16.
   - Stimulus: ch0 samples 32767, then -32768.
   - Required response: out[0]=-32768 and ovf[0]=1. A following sample of -32768 gives out[0]=0 and ovf[0] still 1.
4. SATURATE=0, same stimulus as scenario 3.
   - Required response: out[0]=1 (wrap of -65535) and ovf[0]=1.
5. Clear priority.
   - Stimulus: clear and en asserted in the same cycle after priming, then strobes with 5 and 8.
   - Required response: out_valid=0 and ovf=0 after the clear. First post-clear strobe gives out_valid=0; second gives out[0]=3.
6. Asynchronous reset.
   - Stimulus: assert reset low between clock edges while out_valid=1.
   - Required response: out, out_valid, ovf and prime_cnt go to 0 immediately without waiting for a clock edge. Re-prime is required after release.
